// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcode encoding,
// instruction field positions and small decode helpers.
package alu_pkg;

    localparam int NREGS   = 8;
    localparam int REG_W   = 3;
    localparam int DATA_W  = 8;
    localparam int FLAG_W  = 3;
    localparam int OPC_W   = 4;
    localparam int INSTR_W = 24;

    // Opcode encoding shared with the ALU.
    localparam logic [OPC_W-1:0] OP_ADD     = 4'b0100;
    localparam logic [OPC_W-1:0] OP_CMP     = 4'b0111;
    localparam logic [OPC_W-1:0] OP_LD      = 4'b1000;
    localparam logic [OPC_W-1:0] MAX_OPCODE = 4'd8;

    // Instruction word field positions.
    localparam int OPC_MSB  = 23;
    localparam int OPC_LSB  = 20;
    localparam int RD_MSB   = 19;
    localparam int RD_LSB   = 17;
    localparam int RSA_MSB  = 16;
    localparam int RSA_LSB  = 14;
    localparam int RSB_MSB  = 13;
    localparam int RSB_LSB  = 11;
    localparam int RSV_MSB  = 10;
    localparam int RSV_LSB  = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    // One-hot mask selecting a single register index.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
        reg_onehot = {{(NREGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Opcodes above MAX_OPCODE are dropped by the issue stage.
    function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
        opcode_legal = (op <= MAX_OPCODE);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-in / ALU-bundle-out handshake bundle of the issue stage.
// master = the environment (instruction source and bundle consumer),
// slave  = the issue stage itself.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [OPC_W-1:0]     opcode;
    logic [DATA_W-1:0]    operand_A;
    logic [DATA_W-1:0]    operand_B;
    logic [DATA_W-1:0]    memory_address;
    logic [REG_W-1:0]     out_rd;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, opcode, operand_A, operand_B,
               memory_address, out_rd
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, opcode, operand_A, operand_B,
               memory_address, out_rd
    );

endinterface

// File: rtl/alu_regfile.sv
// 8x8 register file with two combinational read ports (write-first bypass
// from the writeback port) and the architectural flag register.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [FLAG_W-1:0] wb_flag,
    input  logic [REG_W-1:0]  rd_addr_a,
    input  logic [REG_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [FLAG_W-1:0] flag_q
);

    logic [DATA_W-1:0] regs_r [NREGS];

    // Register and flag storage, written by the ALU writeback port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            flag_q <= {FLAG_W{1'b0}};
        end else if (wb_en) begin
            regs_r[wb_addr] <= wb_data;
            flag_q          <= wb_flag;
        end
    end

    // Read port A: a same-cycle writeback to the same index wins.
    always_comb begin
        if (wb_en && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
    end

    // Read port B: a same-cycle writeback to the same index wins.
    always_comb begin
        if (wb_en && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode / operand-fetch stage in front of the 8-bit ALU. Decodes a 24-bit
// instruction, reads two source operands (with writeback bypass) and holds
// the ALU bundle in a single output register.
// Optional build macro ALU_ISSUE_SCOREBOARD_EN adds a pending-destination
// vector that stalls instructions reading a register still in flight.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [FLAG_W-1:0] wb_flag,
    output logic [FLAG_W-1:0] flag_q,
    output logic              illegal_op
);

    logic [OPC_W-1:0]  dec_op_s;
    logic [REG_W-1:0]  dec_rd_s;
    logic [REG_W-1:0]  dec_rsa_s;
    logic [REG_W-1:0]  dec_rsb_s;
    logic [DATA_W-1:0] dec_addr_s;
    logic              unused_rsvd_s;
    logic [DATA_W-1:0] rf_a_s;
    logic [DATA_W-1:0] rf_b_s;
    logic              legal_s;
    logic              hold_free_s;
    logic              in_fire_s;
    logic              out_fire_s;

    assign dec_op_s      = bus.in_instr[OPC_MSB:OPC_LSB];
    assign dec_rd_s      = bus.in_instr[RD_MSB:RD_LSB];
    assign dec_rsa_s     = bus.in_instr[RSA_MSB:RSA_LSB];
    assign dec_rsb_s     = bus.in_instr[RSB_MSB:RSB_LSB];
    assign dec_addr_s    = bus.in_instr[ADDR_MSB:ADDR_LSB];
    // Reserved field carries no meaning.
    assign unused_rsvd_s = ^bus.in_instr[RSV_MSB:RSV_LSB];

    assign legal_s     = opcode_legal(dec_op_s);
    assign hold_free_s = ~bus.out_valid | bus.out_ready;
    assign in_fire_s   = bus.in_valid & bus.in_ready;
    assign out_fire_s  = bus.out_valid & bus.out_ready;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_flag   (wb_flag),
        .rd_addr_a (dec_rsa_s),
        .rd_addr_b (dec_rsb_s),
        .rd_data_a (rf_a_s),
        .rd_data_b (rf_b_s),
        .flag_q    (flag_q)
    );

`ifdef ALU_ISSUE_SCOREBOARD_EN
    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] pending_nxt_s;
    logic [NREGS-1:0] busy_s;
    logic             raw_stall_s;

    // Registers still owed a result: pending ones not being written back
    // right now (bypass covers those), plus the destination of the held
    // bundle, which becomes pending the moment it is accepted.
    always_comb begin
        busy_s = pending_r;
        if (wb_en) begin
            busy_s = busy_s & ~reg_onehot(wb_addr);
        end else begin
            busy_s = busy_s;
        end
        if (bus.out_valid) begin
            busy_s = busy_s | reg_onehot(bus.out_rd);
        end else begin
            busy_s = busy_s;
        end
    end

    assign raw_stall_s = bus.in_valid & (busy_s[dec_rsa_s] | busy_s[dec_rsb_s]);
    assign bus.in_ready = hold_free_s & ~raw_stall_s;

    // Next pending vector: writeback clears, bundle acceptance sets (set wins).
    always_comb begin
        pending_nxt_s = pending_r;
        if (wb_en) begin
            pending_nxt_s = pending_nxt_s & ~reg_onehot(wb_addr);
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (out_fire_s) begin
            pending_nxt_s = pending_nxt_s | reg_onehot(bus.out_rd);
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Pending-destination vector storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {NREGS{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end
`else
    assign bus.in_ready = hold_free_s;
`endif

    // Output bundle register and illegal-opcode pulse. An illegal in_fire can
    // only happen when the register is free, so it simply leaves it empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.opcode         <= {OPC_W{1'b0}};
            bus.operand_A      <= {DATA_W{1'b0}};
            bus.operand_B      <= {DATA_W{1'b0}};
            bus.memory_address <= {DATA_W{1'b0}};
            bus.out_rd         <= {REG_W{1'b0}};
            illegal_op         <= 1'b0;
        end else begin
            illegal_op <= in_fire_s & ~legal_s;
            if (in_fire_s && legal_s) begin
                bus.out_valid      <= 1'b1;
                bus.opcode         <= dec_op_s;
                bus.operand_A      <= rf_a_s;
                bus.operand_B      <= rf_b_s;
                bus.memory_address <= dec_addr_s;
                bus.out_rd         <= dec_rd_s;
            end else if (out_fire_s) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 8-bit ALU.
- Accepts 24-bit instruction words over a valid/ready handshake and decodes opcode, destination and source register fields.
- Reads an 8x8-bit register file and presents a registered {opcode, operand_A, operand_B, memory_address} bundle to the ALU.
- Owns the register file and the 3-bit flag register; both are updated by the ALU writeback port.

Parameters:
- NREGS, 8, register-file depth; register-index width is log2(NREGS) = 3.
- DATA_W, 8, operand/result width; must match the ALU.
- MAX_OPCODE, 4'd8, highest legal opcode; larger values are illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage can accept the instruction this cycle.
- in_instr  in  24  [23:20] opcode, [19:17] rd, [16:14] rs_a, [13:11] rs_b, [10:8] reserved, [7:0] memory_address.
- out_valid  out  1  ALU bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- opcode  out  4  to ALU opcode.
- operand_A  out  8  to ALU operand_A.
- operand_B  out  8  to ALU operand_B.
- memory_address  out  8  to ALU memory_address.
- out_rd  out  3  destination index travelling with the bundle.
- wb_en  in  1  write ALU result this cycle.
- wb_addr  in  3  writeback register index.
- wb_data  in  8  ALU result.
- wb_flag  in  3  ALU flag, captured when wb_en=1.
- flag_q  out  3  architectural flag register.
- illegal_op  out  1  one-cycle pulse when an illegal opcode is dropped.

Behaviour:
- Reset: out_valid=0; opcode, operand_A, operand_B, memory_address, out_rd = 0; all registers = 0; flag_q = 0; illegal_op = 0; in_ready = 1. Reset asserted mid-transfer discards the held bundle.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Output register: in_ready = !out_valid | out_ready. This is a single output register and must have no combinational path from in_valid to out_valid.
- Latency: a legal in_fire at cycle N gives out_valid=1 at N+1. The bundle is held stable until out_fire.
- Legal in_fire: load bundle; out_valid <= 1.
  - operand_A = RF[rs_a] and operand_B = RF[rs_b].
  - Bypass: if wb_en & wb_addr==rs_x in the same cycle, the operand takes wb_data.
- out_fire without a new legal in_fire: out_valid <= 0.
- Illegal opcode (> MAX_OPCODE) on in_fire: instruction consumed and not forwarded; illegal_op=1 for exactly the next cycle; out_valid <= 0 unless a held bundle is still stalled.
- Writeback: RF[wb_addr] <= wb_data and flag_q <= wb_flag on any cycle with wb_en=1, independent of handshake state.
- Reserved bits [10:8] are ignored.

Optional Feature:
- Macro: ALU_ISSUE_SCOREBOARD_EN.
- Enabled: a 3-bit... correction, an NREGS-bit pending vector.
  - Bit rd is set on out_fire; bit wb_addr is cleared on wb_en. If set and clear hit the same index in one cycle, set wins.
  - in_ready is additionally forced to 0 while in_valid=1 and pending[rs_a] or pending[rs_b] is set (RAW stall).
  - A writeback clearing the pending bit in the same cycle releases the stall through bypass.
  - Reset clears the pending vector.
- Disabled: no pending vector and no stall; the software guarantees spacing between dependent instructions.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams matching the ALU encoding (e.g. OP_ADD=4'b0100, OP_CMP=4'b0111, OP_LD=4'b1000);
  - MAX_OPCODE;
  - instruction field bit positions;
  - DATA_W and the flag width of 3.
- Sub-module alu_regfile: 8x8 registers with 2 read ports and 1 write port. It has combinational read with write-first bypass, asynchronous reset to 0, and also holds flag_q.

Test Plan:
- Reset then issue opcode=0100, rs_a=R1=0x02, rs_b=R2=0x27 -> next cycle out_valid=1, opcode=4'b0100, operand_A=0x02, operand_B=0x27.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle stable; out_ready=1 -> one transfer, next instruction loaded in the same cycle.
- wb_en=1, wb_addr=3, wb_data=0xFF in the same cycle as an issue reading rs_b=3 -> operand_B=0xFF; flag_q updates to wb_flag one cycle later.
- Issue opcode=4'b1111 -> out_valid stays 0, illegal_op high for exactly 1 cycle.
- (ALU_ISSUE_SCOREBOARD_EN) Issue rd=4, then issue reading rs_a=4 -> in_ready=0 until wb_en with wb_addr=4; operand_A equals that wb_data.
- Assert rst with out_valid=1 -> out_valid=0, flag_q=0, registers read 0 immediately, without waiting for a clock.
